// File: rtl/bp_pkg.sv
// bp_pkg
// Shared types and constants for the branch-prediction resolve path.
//   bp_entry_t  : one recorded fetch-time prediction
//   BpInstrLen  : fall-through stride of a full-size instruction
//   BpCInstrLen : fall-through stride of a compressed instruction
package bp_pkg;

  localparam int unsigned BpInstrLen  = 4;
  localparam int unsigned BpCInstrLen = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        is_cond;
    logic        is_comp;
  } bp_entry_t;

endpackage

// File: rtl/bp_entry_fifo.sv
// bp_entry_fifo
// Depth-entry circular FIFO of bp_entry_t records. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   push         : write wr_entry at the tail (ignored while full)
//   wr_entry     : record to write
//   pop          : drop the head (ignored while empty)
//   clear        : discard every entry; wins over push and pop
//   head         : oldest entry (meaningful only when not empty)
//   full, empty  : occupancy flags from registered pointers
//   count        : number of entries held
module bp_entry_fifo
  import bp_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  bp_entry_t                wr_entry,
  input  logic                     pop,
  input  logic                     clear,
  output bp_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  bp_entry_t       mem [Depth];

  logic do_push;
  logic do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]) &&
                 (wr_ptr[AddrW] != rd_ptr[AddrW]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AddrW-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer update. Clearing simply collapses both pointers to zero, which
  // also discards any push or pop presented in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: an entry is only ever read after it was written.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear && !rst_i) begin
      mem[wr_ptr[AddrW-1:0]] <= wr_entry;
    end
  end

endmodule

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue
// Execute-side partner of the gshare predictor. Fetch/ID records each
// control-flow prediction in an in-order queue; when EX resolves the oldest
// control-flow instruction the record is popped, compared against the actual
// outcome, and a predictor update plus (on a miss) a redirect are produced
// one cycle later. Branch and mispredict performance counters are kept here.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   pred_*                : prediction record from fetch/ID (valid/ready)
//   ex_valid_i, ex_pc_i,
//   ex_taken_i, ex_target_i : EX resolution of the oldest branch/jump
//   flush_i               : external flush, empties the queue, highest priority
//   ex_br_*_o             : registered predictor update (conditionals only)
//   mispredict_o          : registered one-cycle redirect pulse
//   redirect_pc_o         : correct next PC while mispredict_o is high, else 0
//   order_err_o           : resolve on empty queue or PC mismatch
//   occupancy_o           : current entry count
//   branch_cnt_o, mispredict_cnt_o : wrapping performance counters
module bp_resolve_queue
  import bp_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned CntWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pred_valid_i,
  output logic                   pred_ready_o,
  input  logic [31:0]            pred_pc_i,
  input  logic                   pred_taken_i,
  input  logic [31:0]            pred_target_i,
  input  logic                   pred_is_cond_i,
  input  logic                   pred_is_comp_i,
  input  logic                   ex_valid_i,
  input  logic [31:0]            ex_pc_i,
  input  logic                   ex_taken_i,
  input  logic [31:0]            ex_target_i,
  input  logic                   flush_i,
  output logic                   ex_br_valid_o,
  output logic                   ex_br_taken_o,
  output logic [31:0]            ex_br_instr_addr_o,
  output logic                   mispredict_o,
  output logic [31:0]            redirect_pc_o,
  output logic                   order_err_o,
  output logic [$clog2(Depth):0] occupancy_o,
  output logic [CntWidth-1:0]    branch_cnt_o,
  output logic [CntWidth-1:0]    mispredict_cnt_o
);

  bp_entry_t   new_entry;
  bp_entry_t   head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_clear;

  logic        resolve;
  logic        mis;
  logic        order_err;
  logic        br_update;
  logic [31:0] fall_through;
  logic [31:0] redirect_next;

  assign new_entry = '{
    pc:      pred_pc_i,
    taken:   pred_taken_i,
    target:  pred_target_i,
    is_cond: pred_is_cond_i,
    is_comp: pred_is_comp_i
  };

  // Ready depends on the registered pointers only, so a pop in the same
  // cycle never opens a slot for the current offer.
  assign pred_ready_o = ~fifo_full;

  // A resolve that meets a flush is ignored entirely; only a resolve against
  // a non-empty queue actually consumes and compares the head.
  assign resolve = ex_valid_i & ~fifo_empty & ~flush_i;

  // Wrong direction, or right (taken) direction with the wrong target.
  assign mis = resolve &
               ((head.taken != ex_taken_i) |
                (ex_taken_i & head.taken & (head.target != ex_target_i)));

  assign order_err = ex_valid_i & ~flush_i &
                     (fifo_empty | (ex_pc_i != head.pc));

  assign br_update = resolve & head.is_cond;

  assign fall_through  = head.pc + (head.is_comp ? 32'(BpCInstrLen)
                                                 : 32'(BpInstrLen));
  assign redirect_next = ex_taken_i ? ex_target_i : fall_through;

  // A mispredict squashes every younger entry along with any same-cycle
  // enqueue, since those were fetched down the wrong path.
  assign fifo_clear = flush_i | mis;
  assign fifo_push  = pred_valid_i & ~fifo_full & ~fifo_clear;
  assign fifo_pop   = resolve;

  bp_entry_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (fifo_push),
    .wr_entry (new_entry),
    .pop      (fifo_pop),
    .clear    (fifo_clear),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (occupancy_o)
  );

  // Registered resolve outputs. Every field is zeroed when it does not apply
  // so downstream logic can treat non-strobed values as don't-care safely.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_br_valid_o      <= 1'b0;
      ex_br_taken_o      <= 1'b0;
      ex_br_instr_addr_o <= '0;
      mispredict_o       <= 1'b0;
      redirect_pc_o      <= '0;
      order_err_o        <= 1'b0;
    end else begin
      ex_br_valid_o      <= br_update;
      ex_br_taken_o      <= br_update & ex_taken_i;
      ex_br_instr_addr_o <= br_update ? head.pc : 32'h0;
      mispredict_o       <= mis;
      redirect_pc_o      <= mis ? redirect_next : 32'h0;
      order_err_o        <= order_err;
    end
  end

  // Performance counters move on the same edge as the registered outputs
  // and wrap naturally at their width.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else begin
      if (br_update) begin
        branch_cnt_o <= branch_cnt_o + CntWidth'(1);
      end
      if (mis) begin
        mispredict_cnt_o <= mispredict_cnt_o + CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb_bp_resolve_queue
// Randomised and directed stimulus against a queue-based reference model.
// Expected resolve events go into a scoreboard queue; a separate monitor pops
// and compares whenever the DUT raises an update, mispredict or order error.
// The counters use a narrow width so that wrap-around happens during the run.
module tb_bp_resolve_queue;

  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 4;
  localparam int          CntMod = 1 << CntW;

  logic                   clk;
  logic                   rst;
  logic                   pred_valid;
  logic                   pred_ready;
  logic [31:0]            pred_pc;
  logic                   pred_taken;
  logic [31:0]            pred_target;
  logic                   pred_is_cond;
  logic                   pred_is_comp;
  logic                   ex_valid;
  logic [31:0]            ex_pc;
  logic                   ex_taken;
  logic [31:0]            ex_target;
  logic                   flush;
  logic                   ex_br_valid;
  logic                   ex_br_taken;
  logic [31:0]            ex_br_instr_addr;
  logic                   mispredict;
  logic [31:0]            redirect_pc;
  logic                   order_err;
  logic [$clog2(Depth):0] occupancy;
  logic [CntW-1:0]        branch_cnt;
  logic [CntW-1:0]        mispredict_cnt;

  bp_resolve_queue #(
    .Depth    (Depth),
    .CntWidth (CntW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .pred_valid_i       (pred_valid),
    .pred_ready_o       (pred_ready),
    .pred_pc_i          (pred_pc),
    .pred_taken_i       (pred_taken),
    .pred_target_i      (pred_target),
    .pred_is_cond_i     (pred_is_cond),
    .pred_is_comp_i     (pred_is_comp),
    .ex_valid_i         (ex_valid),
    .ex_pc_i            (ex_pc),
    .ex_taken_i         (ex_taken),
    .ex_target_i        (ex_target),
    .flush_i            (flush),
    .ex_br_valid_o      (ex_br_valid),
    .ex_br_taken_o      (ex_br_taken),
    .ex_br_instr_addr_o (ex_br_instr_addr),
    .mispredict_o       (mispredict),
    .redirect_pc_o      (redirect_pc),
    .order_err_o        (order_err),
    .occupancy_o        (occupancy),
    .branch_cnt_o       (branch_cnt),
    .mispredict_cnt_o   (mispredict_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    bit          tk;
    logic [31:0] tg;
    bit          cond;
    bit          comp;
  } model_entry_t;

  typedef struct {
    int          due;
    bit          brv;
    bit          brt;
    logic [31:0] bra;
    bit          mis;
    logic [31:0] rpc;
    bit          oe;
  } exp_t;

  model_entry_t modelQ[$];
  exp_t         expQ[$];
  int           modelBr;
  int           modelMis;
  int           cyc;
  int           total;
  int           bad;
  bit           monEn;

  // Free-running clock and cycle stamp used to pair expectations with outputs.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports each miss.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, actual, required, cyc);
    end
  endtask

  // Drives one cycle of inputs at a negedge, first checking the state the DUT
  // settled into after the previous edge, then advancing the reference model.
  task automatic applyStimulus(input bit pv, input logic [31:0] ppc,
                               input bit ptk, input logic [31:0] ptg,
                               input bit pcond, input bit pcomp,
                               input bit ev, input logic [31:0] epc,
                               input bit etk, input logic [31:0] etg,
                               input bit fl, input bit rs);
    bit           isFull;
    bit           mis;
    exp_t         e;
    model_entry_t h;
    model_entry_t n;

    isFull = (modelQ.size() == Depth);
    checkOutput("occupancy", 32'(occupancy), 32'(modelQ.size()));
    checkOutput("pred_ready", 32'(pred_ready), 32'(!isFull));
    checkOutput("branch_cnt", 32'(branch_cnt), 32'(modelBr));
    checkOutput("mispredict_cnt", 32'(mispredict_cnt), 32'(modelMis));

    rst          = rs;
    pred_valid   = pv;
    pred_pc      = ppc;
    pred_taken   = ptk;
    pred_target  = ptg;
    pred_is_cond = pcond;
    pred_is_comp = pcomp;
    ex_valid     = ev;
    ex_pc        = epc;
    ex_taken     = etk;
    ex_target    = etg;
    flush        = fl;

    mis = 1'b0;
    if (rs) begin
      modelQ.delete();
      modelBr  = 0;
      modelMis = 0;
    end else if (fl) begin
      modelQ.delete();
    end else begin
      if (ev) begin
        e = '{due: cyc + 1, brv: 0, brt: 0, bra: 0, mis: 0, rpc: 0, oe: 0};
        if (modelQ.size() == 0) begin
          e.oe = 1'b1;
        end else begin
          h = modelQ.pop_front();
          if (etk != h.tk) mis = 1'b1;
          else if (etk && h.tg != etg) mis = 1'b1;
          e.oe  = (epc != h.pc);
          e.brv = h.cond;
          e.brt = h.cond && etk;
          e.bra = h.cond ? h.pc : 32'h0;
          e.mis = mis;
          if (mis) e.rpc = etk ? etg : h.pc + (h.comp ? 32'd2 : 32'd4);
          if (h.cond) modelBr = (modelBr + 1) % CntMod;
          if (mis) begin
            modelMis = (modelMis + 1) % CntMod;
            modelQ.delete();
          end
        end
        if (e.brv || e.mis || e.oe) expQ.push_back(e);
      end
      if (pv && !isFull && !mis) begin
        n = '{pc: ppc, tk: ptk, tg: ptg, cond: pcond, comp: pcomp};
        modelQ.push_back(n);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic enq(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                     input bit cond, input bit comp);
    applyStimulus(1, pc, tk, tg, cond, comp, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic res(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, pc, tk, tg, 0, 0);
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT signals an
  // event, and flags expectations whose cycle passed with no DUT event.
  always @(negedge clk) begin
    exp_t e;
    if (monEn) begin
      if (ex_br_valid || mispredict || order_err) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_event", {29'h0, ex_br_valid, mispredict, order_err}, 32'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("event_cycle", 32'(cyc), 32'(e.due));
          checkOutput("ex_br_valid", 32'(ex_br_valid), 32'(e.brv));
          checkOutput("ex_br_taken", 32'(ex_br_taken), 32'(e.brt));
          checkOutput("ex_br_instr_addr", ex_br_instr_addr, e.bra);
          checkOutput("mispredict", 32'(mispredict), 32'(e.mis));
          checkOutput("redirect_pc", redirect_pc, e.rpc);
          checkOutput("order_err", 32'(order_err), 32'(e.oe));
        end
      end else begin
        checkOutput("quiet_redirect_pc", redirect_pc, 32'h0);
        if (expQ.size() != 0 && expQ[0].due <= cyc) begin
          e = expQ.pop_front();
          checkOutput("missing_event", 32'h0, {29'h0, e.brv, e.mis, e.oe});
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    logic [31:0] rtg;
    logic [31:0] epc;
    logic [31:0] etg;
    bit          pv;
    bit          ev;
    bit          ptk;
    bit          etk;
    int          sel;

    total    = 0;
    bad      = 0;
    modelBr  = 0;
    modelMis = 0;
    monEn    = 1'b0;
    rst = 1'b1; pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
    pred_is_cond = 0; pred_is_comp = 0; ex_valid = 0; ex_pc = 0;
    ex_taken = 0; ex_target = 0; flush = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_ex_br_valid", 32'(ex_br_valid), 32'h0);
    checkOutput("rst_ex_br_taken", 32'(ex_br_taken), 32'h0);
    checkOutput("rst_ex_br_instr_addr", ex_br_instr_addr, 32'h0);
    checkOutput("rst_mispredict", 32'(mispredict), 32'h0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_order_err", 32'(order_err), 32'h0);
    checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("rst_pred_ready", 32'(pred_ready), 32'h1);
    checkOutput("rst_cnts", {branch_cnt, mispredict_cnt}, 32'h0);
    monEn = 1'b1;

    $display("[TB] directed: correct taken conditional");
    enq(32'h100, 1, 32'h140, 1, 0);
    res(32'h100, 1, 32'h140);
    idle();

    $display("[TB] directed: direction mispredicts and fall-through");
    enq(32'h200, 0, 32'h0, 1, 1);
    res(32'h200, 1, 32'h180);
    enq(32'h200, 1, 32'h240, 1, 1);
    res(32'h200, 0, 32'h0);
    enq(32'hFFFF_FFFC, 1, 32'h40, 1, 0);
    res(32'hFFFF_FFFC, 0, 32'h0);
    idle();

    $display("[TB] directed: full queue rejects even with same-cycle pop");
    for (int i = 0; i < 4; i++) enq(32'h10 + 32'(4 * i), 0, 32'h0, 1, 0);
    applyStimulus(1, 32'h80, 0, 0, 1, 0, 1, 32'h10, 0, 0, 0, 0);
    for (int i = 1; i < 4; i++) res(32'h10 + 32'(4 * i), 0, 32'h0);
    idle();

    $display("[TB] directed: mispredict squashes queue and same-cycle enqueue");
    for (int i = 0; i < 3; i++) enq(32'h500 + 32'(4 * i), 0, 32'h0, 1, 0);
    applyStimulus(1, 32'h600, 0, 0, 1, 0, 1, 32'h500, 1, 32'h700, 0, 0);
    res(32'h504, 0, 32'h0);
    idle();

    $display("[TB] directed: correct jump");
    enq(32'h300, 1, 32'h400, 0, 0);
    res(32'h300, 1, 32'h400);
    idle();

    $display("[TB] directed: flush beats mispredicting resolve");
    enq(32'h800, 0, 32'h0, 1, 0);
    enq(32'h804, 0, 32'h0, 1, 0);
    applyStimulus(1, 32'h808, 0, 0, 1, 0, 1, 32'h800, 1, 32'h900, 1, 0);
    idle();

    $display("[TB] directed: mid-run reset with entries in flight");
    enq(32'hA00, 1, 32'hA40, 1, 0);
    enq(32'hA04, 0, 32'h0, 0, 1);
    applyStimulus(1, 32'hA08, 0, 0, 1, 0, 1, 32'hA00, 1, 32'hA40, 0, 1);
    idle();

    $display("[TB] random phase");
    for (int n = 0; n < 3000; n++) begin
      pv  = ($urandom % 100) < 60;
      sel = int'($urandom % 10);
      rpc = (sel == 0) ? 32'hFFFF_FFFE : (sel == 1) ? 32'hFFFF_FFFC
                                                    : ($urandom & 32'hFFFF_FFFE);
      ptk = $urandom % 2;
      rtg = $urandom & 32'hFFFF_FFFE;
      if (modelQ.size() > 0) begin
        ev  = ($urandom % 100) < 50;
        epc = (($urandom % 100) < 92) ? modelQ[0].pc : $urandom;
        etk = (($urandom % 100) < 70) ? modelQ[0].tk : !modelQ[0].tk;
        etg = (modelQ[0].tk && ($urandom % 100) < 80) ? modelQ[0].tg : $urandom;
      end else begin
        ev  = ($urandom % 100) < 5;
        epc = $urandom;
        etk = $urandom % 2;
        etg = $urandom;
      end
      applyStimulus(pv, rpc, ptk, rtg, $urandom % 4 != 0, $urandom % 2,
                    ev, epc, etk, etg, ($urandom % 100) < 3, ($urandom % 200) == 0);
    end

    idle();
    idle();
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_resolve_queue.md
Name: bp_resolve_queue

Overview:
- Execute-side counterpart of the gshare predictor.
- Records each branch/jump prediction made at fetch in an in-order queue and pairs it with the EX-stage resolution.
- Generates the predictor update triple (ex_br_valid/taken/instr_addr) and a mispredict redirect with flush.
- Sits between the fetch/ID prediction path and the EX branch unit; also keeps branch and mispredict performance counters.

Parameters:
- Depth, 4, number of in-flight predicted control-flow entries; power of 2, ≥2.
- CntWidth, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- pred_valid_i  in  1  prediction record offered by fetch/ID
- pred_ready_o  out  1  queue can accept a record (= not full)
- pred_pc_i  in  32  PC of the branch/jump
- pred_taken_i  in  1  predicted taken
- pred_target_i  in  32  predicted target PC (valid when pred_taken_i)
- pred_is_cond_i  in  1  conditional branch (B/CB) = 1; jump (J/CJ) = 0
- pred_is_comp_i  in  1  compressed instruction (fall-through PC +2, else +4)
- ex_valid_i  in  1  EX resolves the oldest control-flow instruction this cycle
- ex_pc_i  in  32  PC of the resolving instruction
- ex_taken_i  in  1  actual direction
- ex_target_i  in  32  actual taken target
- flush_i  in  1  external flush (exception/interrupt); discards all entries
- ex_br_valid_o  out  1  predictor update strobe
- ex_br_taken_o  out  1  predictor update direction
- ex_br_instr_addr_o  out  32  predictor update PC
- mispredict_o  out  1  one-cycle redirect pulse
- redirect_pc_o  out  32  correct next PC when mispredict_o = 1
- order_err_o  out  1  one-cycle pulse: resolve with empty queue or PC mismatch
- occupancy_o  out  $clog2(Depth)+1  current entry count
- branch_cnt_o  out  CntWidth  count of resolved conditional branches
- mispredict_cnt_o  out  CntWidth  count of mispredicts

Behaviour:
- Reset (rst_i = 1 at a clock edge): queue empty. All outputs 0, including both counters and occupancy_o. pred_ready_o = 1 in the cycle after reset.
- Queue structure: circular buffer. Read and write pointers are $clog2(Depth)+1 bits wide; the MSB is the wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- pred_ready_o = ~full, combinational from registered pointers only. No enqueue while full, even if a pop occurs in the same cycle.
- Enqueue: pred_valid_i & pred_ready_o writes one entry at the write pointer.
- Resolve: ex_valid_i with a non-empty queue pops the head.
  - mis = (head.taken != ex_taken_i) | (ex_taken_i & head.taken & head.target != ex_target_i).
  - If ex_pc_i != head.pc: order_err_o pulses and the head is still popped/compared.
- ex_valid_i with an empty queue: no pop, order_err_o pulses, no update, no mispredict.
- Outputs are registered, 1-cycle latency after the resolve edge:
  - ex_br_valid_o = 1 only if head.is_cond, with ex_br_taken_o = ex_taken_i and ex_br_instr_addr_o = head.pc. Otherwise all three = 0.
  - mispredict_o = mis.
  - redirect_pc_o = ex_taken_i ? ex_target_i : head.pc + (head.is_comp ? 2 : 4), 32-bit wrap. redirect_pc_o holds 0 when mispredict_o = 0.
- Mispredict flush: on the resolving edge with mis = 1, all remaining entries are discarded (pointers reset to equal). A same-cycle enqueue is dropped.
- flush_i has highest priority. On that edge the queue empties, the same-cycle resolve produces no update, no mispredict and no count, and the same-cycle enqueue is dropped. order_err_o is also suppressed.
- Simultaneous enqueue + non-mispredicting resolve (not full): both take effect; occupancy is unchanged.
- Counters:
  - branch_cnt_o increments on each conditional resolve.
  - mispredict_cnt_o increments on each mis (conditional or jump).
  - Both wrap modulo 2^CntWidth and change on the same edge as the registered outputs become valid.
- rst_i mid-operation discards all entries and pending outputs; no update is emitted for in-flight entries.

Decomposition:
- bp_pkg holds:
  - bp_entry_t packed struct {pc[31:0], taken, target[31:0], is_cond, is_comp}.
  - Constants BpInstrLen = 4 and BpCInstrLen = 2.
- Sub-module bp_entry_fifo: a Depth-entry bp_entry_t circular FIFO with push, pop, clear, full, empty and count. bp_resolve_queue holds the compare, redirect, output registers and counters.

Test Plan:
- Reset, then enqueue {pc=0x100, cond, taken, tgt=0x140} and resolve taken to 0x140 → next cycle ex_br_valid_o=1, ex_br_taken_o=1, ex_br_instr_addr_o=0x100, mispredict_o=0, branch_cnt_o=1.
- Enqueue cond not-taken {pc=0x200, comp}, resolve taken to 0x180 → mispredict_o=1, redirect_pc_o=0x180, mispredict_cnt_o=1. Resolve same entry class predicted taken, actual not-taken at pc=0x200 comp → redirect_pc_o=0x202.
- Fill 4 entries → pred_ready_o=0, occupancy_o=4. A 5th pred_valid_i with a non-mispredicting resolve in the same cycle is not accepted → occupancy_o=3.
- Three entries queued, the first resolves mispredicted with a same-cycle enqueue → occupancy_o=0 next cycle, and a subsequent ex_valid_i gives order_err_o=1.
- Jump entry {pc=0x300, uncond, taken, tgt=0x400} resolved correctly → ex_br_valid_o=0, mispredict_o=0, branch_cnt_o unchanged.
- flush_i asserted with ex_valid_i on a mispredicting head → no mispredict_o, no ex_br_valid_o, occupancy_o=0. Force mispredict_cnt_o=0xFFFFFFFF, then mispredict → counter wraps to 0.
